// File: rtl/booth4_pkg.sv
// rtl/booth4_pkg.sv - shared types and constants for the radix-4 Booth sequential multiplier
package booth4_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

endpackage

// File: rtl/booth4_enc.sv
// rtl/booth4_enc.sv - radix-4 Booth triplet {b[2i+1],b[2i],b[2i-1]} to digit controls
module booth4_enc
  import booth4_pkg::*;
(
  input  logic [2:0]   triplet,
  output booth_digit_t digit
);

  logic one;

  assign one       = triplet[1] ^ triplet[0];
  assign digit.neg = triplet[2];
  assign digit.one = one;
  assign digit.two = ~one & (triplet[2] ^ triplet[1]);

endmodule

// File: rtl/booth4_seq_mult.sv
// rtl/booth4_seq_mult.sv - sequential radix-4 Booth signed multiplier, one digit per cycle; BOOTH4_SEQ_OUTREG_EN adds an output register stage
module booth4_seq_mult
  import booth4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int STEPS = WIDTH / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t         state;
  logic [WIDTH-1:0] mc;
  logic [WIDTH:0] mp_sh;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  acc;

  booth_digit_t   digit;
  logic [PW-1:0]  mc_ext;
  logic [PW-1:0]  mag;
  logic [PW-1:0]  pp;

  // mp_sh is shifted two bits per step, so the current triplet is always its low three bits
  booth4_enc u_enc (
    .triplet (mp_sh[2:0]),
    .digit   (digit)
  );

  // Sign-extend before doubling so that -2^(WIDTH-1) * 2 stays exact
  always_comb begin
    mc_ext = {{WIDTH{mc[WIDTH-1]}}, mc};
    mag    = '0;
    if (digit.two)
      mag = mc_ext << 1;
    else if (digit.one)
      mag = mc_ext;
    pp = (digit.neg ? (~mag + PW'(1)) : mag) << {cnt, 1'b0};
  end

`ifdef BOOTH4_SEQ_OUTREG_EN
  logic          fin;
  logic [PW-1:0] prod_q;
  assign product = prod_q;
`else
  assign product = acc;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mc        <= '0;
      mp_sh     <= '0;
      cnt       <= '0;
      acc       <= '0;
`ifdef BOOTH4_SEQ_OUTREG_EN
      fin       <= 1'b0;
      prod_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mc       <= mcand;
            mp_sh    <= {mplier, 1'b0};
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
`ifdef BOOTH4_SEQ_OUTREG_EN
          if (fin) begin
            prod_q    <= acc;
            fin       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc   <= acc + pp;
            mp_sh <= mp_sh >> 2;
            if (cnt == LAST)
              fin <= 1'b1;
            else
              cnt <= cnt + CW'(1);
          end
`else
          acc   <= acc + pp;
          mp_sh <= mp_sh >> 2;
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_seq_mult.sv
// tb/tb_booth4_seq_mult.sv - self-checking bench for booth4_seq_mult with a cycle-level reference model
module tb_booth4_seq_mult;

`ifdef BOOTH4_SEQ_OUTREG_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] mcand = '0;
  logic signed [15:0] mplier = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [31:0]        product;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model: phase 0 = waiting for operands, 1 = computing, 2 = result offered
  int          m_ph = 0;
  int          m_cnt = 0;
  bit          m_zero = 1'b1;
  logic [31:0] m_exp = '0;

  booth4_seq_mult #(.WIDTH(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge sys_clk) begin
    longint p;
    if (sys_rst) begin
      m_ph   = 0;
      m_zero = 1'b1;
    end else begin
      case (m_ph)
        0: if (in_valid) begin
          p      = longint'(mcand) * longint'(mplier);
          m_exp  = p[31:0];
          m_cnt  = LAT;
          m_ph   = 1;
          m_zero = 1'b0;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_ph = 2;
        end
        default: if (out_ready) m_ph = 0;
      endcase
    end
  end

  always @(negedge sys_clk) begin
    if (check_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ph == 0});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ph == 2});
      if (m_ph == 2) chk("product", product, m_exp);
      if (m_ph == 0 && m_zero) chk("product_after_reset", product, 32'd0);
    end
  end

  task automatic do_op(input logic signed [15:0] a, input logic signed [15:0] b, input int hold,
                       input bit noise, input bit use_lit, input logic [31:0] lit);
    int n;
    logic [31:0] first;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid  = 1'b1;
    mcand     = a;
    mplier    = b;
    out_ready = (hold == 0);
    @(negedge sys_clk);
    in_valid = noise;
    mcand    = 16'($urandom);
    mplier   = 16'($urandom);
    if (noise) begin
      repeat (3) begin
        @(negedge sys_clk);
        mcand  = 16'($urandom);
        mplier = 16'($urandom);
      end
      in_valid = 1'b0;
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    if (out_valid !== 1'b1) begin
      chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      return;
    end
    first = product;
    if (use_lit) chk("product_literal", product, lit);
    for (int i = 0; i < hold; i++) begin
      @(negedge sys_clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_product", product, first);
    end
    out_ready = 1'b1;
    @(negedge sys_clk);
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    check_en = 1'b1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_product", product, 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    do_op(16'sd3, 16'sd5, 0, 1'b0, 1'b1, 32'h0000_000F);
    chk("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
    do_op(-16'sd32768, -16'sd32768, 0, 1'b0, 1'b1, 32'h4000_0000);
    do_op(16'sd32767, -16'sd32768, 0, 1'b0, 1'b1, 32'hC000_8000);
    do_op(-16'sd1, 16'sd1, 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    do_op(-16'sd7, 16'sd6, 0, 1'b0, 1'b1, 32'hFFFF_FFD6);
    do_op(16'sd12345, -16'sd2, 0, 1'b0, 1'b1, 32'hFFFF_9F8E);
    do_op(-16'sd32768, 16'sd32767, 5, 1'b0, 1'b1, 32'hC000_8000);
    do_op(16'sd100, 16'sd200, 0, 1'b1, 1'b1, 32'h0000_4E20);
    do_op(16'sd0, -16'sd1234, 0, 1'b0, 1'b1, 32'h0000_0000);

    // Reset lands on the fourth CALC edge of an operation
    while (in_ready !== 1'b1) @(negedge sys_clk);
    in_valid = 1'b1;
    mcand    = 16'sd100;
    mplier   = -16'sd200;
    @(negedge sys_clk);
    in_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("midcalc_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midcalc_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midcalc_rst_product", product, 32'd0);
    do_op(-16'sd7, 16'sd6, 0, 1'b0, 1'b1, 32'hFFFF_FFD6);

    for (int k = 0; k < 1000; k++)
      do_op(16'($urandom), 16'($urandom), (k % 97 == 0) ? 3 : 0, 1'b0, 1'b0, 32'd0);

    repeat (2) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
